// File: rtl/ddr3_mem_pkg.sv
// Shared DDR3 command encodings, operation opcodes, bank states and queue payload.
package ddr3_mem_pkg;

    // {CS_N, RAS_N, CAS_N, WE_N} pin encodings; any pattern with CS_N=1 is DESELECT
    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_ZQ  = 4'b0110;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    // Payload field widths sized for the largest DDR3 geometry (8 banks, A15:A0)
    localparam int unsigned PKT_BANK_W = 3;
    localparam int unsigned PKT_ADDR_W = 16;

    typedef enum logic [2:0] {
        OP_ACT = 3'd0,
        OP_RD  = 3'd1,
        OP_WR  = 3'd2,
        OP_PRE = 3'd3,
        OP_REF = 3'd4,
        OP_MRS = 3'd5
    } ddr3_op_t;

    typedef enum logic [1:0] {
        BANK_IDLE       = 2'd0,
        BANK_ACTIVATING = 2'd1,
        BANK_ACTIVE     = 2'd2
    } bank_state_t;

    typedef struct packed {
        ddr3_op_t                op;
        logic [PKT_BANK_W-1:0]   bank;
        logic [PKT_ADDR_W-1:0]   addr;
        logic                    ap;
    } ddr3_op_pkt_t;

endpackage

// File: rtl/ddr3_op_fifo.sv
// Show-ahead FIFO of decoded operations; the head entry is readable without a pop.
module ddr3_op_fifo
    import ddr3_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  ddr3_op_pkt_t push_data,
    input  logic         pop,
    output ddr3_op_pkt_t head,
    output logic         empty,
    output logic         full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    ddr3_op_pkt_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full queue is still taken when the same edge pops
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_cmd_decode.sv
// DDR3 command front end: pin decode, per-bank row/tRCD tracking, and operation queue.
module ddr3_cmd_decode
    import ddr3_mem_pkg::*;
#(
    parameter int unsigned NUM_BANKS  = 8,
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned T_RCD      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         cpu_clk,
    input  logic                         reset,
    input  logic                         cs_n,
    input  logic                         ras_n,
    input  logic                         cas_n,
    input  logic                         we_n,
    input  logic [$clog2(NUM_BANKS)-1:0] ba,
    input  logic [ADDR_W-1:0]            addr,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2:0]                   out_op,
    output logic [$clog2(NUM_BANKS)-1:0] out_bank,
    output logic [ADDR_W-1:0]            out_addr,
    output logic                         out_ap,
    output logic [NUM_BANKS-1:0]         bank_open,
    output logic                         err_illegal,
    output logic                         err_overflow
);

    localparam int unsigned BA_W          = $clog2(NUM_BANKS);
    localparam int unsigned CNT_W         = (T_RCD > 1) ? $clog2(T_RCD) : 1;
    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
    localparam logic DIRECT_ACTIVE        = (T_RCD == 1);

    ddr3_op_t       cmd_op;
    logic           cmd_valid;
    logic           cmd_zq;
    logic           cmd_legal;
    logic           accept;
    logic           illegal_c;
    logic           overflow_c;
    logic           ap_bit;
    logic           pop;
    logic           fifo_empty;
    logic           fifo_full;
    logic           ready_q;
    logic [NUM_BANKS-1:0] bank_idle;
    logic [NUM_BANKS-1:0] bank_active;
    ddr3_op_pkt_t   push_pkt;
    ddr3_op_pkt_t   head_pkt;
    logic           unused_head_bits;

    assign ap_bit = addr[10];

    // Pin decode; DESELECT and NOP leave cmd_valid low, ZQ is flagged as illegal
    always_comb begin
        cmd_valid = 1'b0;
        cmd_zq    = 1'b0;
        cmd_op    = OP_ACT;
        case ({cs_n, ras_n, cas_n, we_n})
            CMD_ACT: begin cmd_valid = 1'b1; cmd_op = OP_ACT; end
            CMD_RD:  begin cmd_valid = 1'b1; cmd_op = OP_RD;  end
            CMD_WR:  begin cmd_valid = 1'b1; cmd_op = OP_WR;  end
            CMD_PRE: begin cmd_valid = 1'b1; cmd_op = OP_PRE; end
            CMD_REF: begin cmd_valid = 1'b1; cmd_op = OP_REF; end
            CMD_MRS: begin cmd_valid = 1'b1; cmd_op = OP_MRS; end
            CMD_ZQ:  cmd_zq = 1'b1;
            default: ;
        endcase
    end

    // Legality against current bank state, plus queue payload assembly
    always_comb begin
        cmd_legal = 1'b0;
        case (cmd_op)
            OP_ACT:        cmd_legal = bank_idle[ba];
            OP_RD, OP_WR:  cmd_legal = bank_active[ba];
            OP_PRE:        cmd_legal = 1'b1;
            default:       cmd_legal = &bank_idle;
        endcase
        accept     = cmd_valid & cmd_legal;
        illegal_c  = (cmd_valid & ~cmd_legal) | cmd_zq;
        overflow_c = accept & fifo_full & ~pop;

        push_pkt      = '0;
        push_pkt.op   = cmd_op;
        push_pkt.bank = PKT_BANK_W'(ba);
        push_pkt.addr = PKT_ADDR_W'(addr);
        push_pkt.ap   = (cmd_op == OP_RD || cmd_op == OP_WR || cmd_op == OP_PRE) ? ap_bit : 1'b0;
    end

    // Per-bank row state machine with tRCD countdown
    for (genvar i = 0; i < int'(NUM_BANKS); i++) begin : g_bank
        bank_state_t      state;
        bank_state_t      state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             sel;

        assign sel            = (ba == BA_W'(i));
        assign bank_idle[i]   = (state == BANK_IDLE);
        assign bank_active[i] = (state == BANK_ACTIVE);

        // Next state; a precharge wins over any other transition including tRCD expiry
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            if (accept && cmd_op == OP_PRE && (ap_bit || sel)) begin
                state_nxt = BANK_IDLE;
                cnt_nxt   = '0;
            end else begin
                case (state)
                    BANK_IDLE: begin
                        if (accept && cmd_op == OP_ACT && sel) begin
                            state_nxt = DIRECT_ACTIVE ? BANK_ACTIVE : BANK_ACTIVATING;
                            cnt_nxt   = DIRECT_ACTIVE ? '0 : RCD_LOAD;
                        end
                    end
                    BANK_ACTIVATING: begin
                        if (cnt <= CNT_W'(1)) begin
                            state_nxt = BANK_ACTIVE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt - CNT_W'(1);
                        end
                    end
                    BANK_ACTIVE: begin
                        if (accept && (cmd_op == OP_RD || cmd_op == OP_WR) && sel && ap_bit) begin
                            state_nxt = BANK_IDLE;
                        end
                    end
                    default: begin
                        state_nxt = BANK_IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end

        // Bank state register
        always_ff @(posedge cpu_clk) begin
            if (reset) begin
                state <= BANK_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end
    end

    assign pop = out_valid & out_ready;

    ddr3_op_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (cpu_clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_pkt),
        .pop       (pop),
        .head      (head_pkt),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Error pulses and the post-reset enable that holds in_ready low during reset
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            err_illegal  <= illegal_c;
            err_overflow <= overflow_c;
            ready_q      <= 1'b1;
        end
    end

    assign in_ready         = ready_q & ~fifo_full;
    assign out_valid        = ~fifo_empty;
    assign out_op           = head_pkt.op;
    assign out_bank         = head_pkt.bank[BA_W-1:0];
    assign out_addr         = head_pkt.addr[ADDR_W-1:0];
    assign out_ap           = head_pkt.ap;
    assign bank_open        = ~bank_idle;
    assign unused_head_bits = ^{head_pkt.addr, head_pkt.bank};

endmodule

// File: tb/tb_ddr3_cmd_decode.sv
// Directed, table-driven bench for ddr3_cmd_decode with default parameters.
module tb_ddr3_cmd_decode;
    import ddr3_mem_pkg::*;

    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_ZQ  = 4'b0110;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_DES = 4'b1111;

    localparam logic [2:0] E_ACT = 3'd0;
    localparam logic [2:0] E_RD  = 3'd1;
    localparam logic [2:0] E_WR  = 3'd2;
    localparam logic [2:0] E_PRE = 3'd3;
    localparam logic [2:0] E_REF = 3'd4;
    localparam logic [2:0] E_MRS = 3'd5;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [2:0]  out_bank;
    logic [13:0] out_addr;
    logic        out_ap;
    logic [7:0]  bank_open;
    logic        err_illegal;
    logic        err_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [13:0] addr;
        logic        ordy;
        logic        ev;
        logic [2:0]  eop;
        logic [2:0]  eb;
        logic [13:0] ea;
        logic        eap;
        logic [7:0]  eopen;
        logic        eill;
        logic        eovf;
        logic        eirdy;
    } vec_t;

    vec_t vecs[$];

    ddr3_cmd_decode dut (
        .cpu_clk      (cpu_clk),
        .reset        (reset),
        .cs_n         (cs_n),
        .ras_n        (ras_n),
        .cas_n        (cas_n),
        .we_n         (we_n),
        .ba           (ba),
        .addr         (addr),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_bank     (out_bank),
        .out_addr     (out_addr),
        .out_ap       (out_ap),
        .bank_open    (bank_open),
        .err_illegal  (err_illegal),
        .err_overflow (err_overflow)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Head fields are only meaningful while valid, so they are zeroed otherwise
    function automatic logic [32:0] pack(logic v, logic [2:0] op, logic [2:0] b, logic [13:0] a,
                                         logic ap, logic [7:0] o, logic i, logic f, logic r);
        if (!v) begin
            op = '0; b = '0; a = '0; ap = 1'b0;
        end
        return {v, op, b, a, ap, o, i, f, r};
    endfunction

    function automatic logic [32:0] observe();
        return pack(out_valid, out_op, out_bank, out_addr, out_ap, bank_open,
                    err_illegal, err_overflow, in_ready);
    endfunction

    task automatic check(string nm, logic [32:0] act, logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (v,op,bank,addr,ap,open,ill,ovf,irdy)", nm, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] c, logic [2:0] b, logic [13:0] a, logic r);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba        = b;
        addr      = a;
        out_ready = r;
    endtask

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic add(logic [3:0] c, logic [2:0] b, logic [13:0] a, logic r,
                       logic ev, logic [2:0] eop, logic [2:0] eb, logic [13:0] ea, logic eap,
                       logic [7:0] eo, logic ei, logic ef, logic er);
        vec_t v;
        v.cmd = c; v.ba = b; v.addr = a; v.ordy = r;
        v.ev = ev; v.eop = eop; v.eb = eb; v.ea = ea; v.eap = eap;
        v.eopen = eo; v.eill = ei; v.eovf = ef; v.eirdy = er;
        vecs.push_back(v);
    endtask

    initial begin
        // Draining sequence (out_ready=1): head after each edge is the command just accepted
        add(C_ACT, 2, 14'h005, 1, 1, E_ACT, 2, 14'h005, 0, 8'h04, 0, 0, 1);
        add(C_ACT, 0, 14'h012, 1, 1, E_ACT, 0, 14'h012, 0, 8'h05, 0, 0, 1);
        add(C_NOP, 0, 14'h000, 1, 0, 0, 0, 0, 0, 8'h05, 0, 0, 1);
        add(C_RD,  0, 14'h000, 1, 0, 0, 0, 0, 0, 8'h05, 1, 0, 1);
        add(C_RD,  0, 14'h000, 1, 0, 0, 0, 0, 0, 8'h05, 1, 0, 1);
        add(C_RD,  0, 14'h008, 1, 1, E_RD,  0, 14'h008, 0, 8'h05, 0, 0, 1);
        add(C_RD,  0, 14'h407, 1, 1, E_RD,  0, 14'h407, 1, 8'h04, 0, 0, 1);
        add(C_WR,  0, 14'h003, 1, 0, 0, 0, 0, 0, 8'h04, 1, 0, 1);
        add(C_WR,  2, 14'h010, 1, 1, E_WR,  2, 14'h010, 0, 8'h04, 0, 0, 1);
        add(C_PRE, 2, 14'h000, 1, 1, E_PRE, 2, 14'h000, 0, 8'h00, 0, 0, 1);
        add(C_ACT, 1, 14'h020, 1, 1, E_ACT, 1, 14'h020, 0, 8'h02, 0, 0, 1);
        add(C_ACT, 3, 14'h030, 1, 1, E_ACT, 3, 14'h030, 0, 8'h0A, 0, 0, 1);
        add(C_REF, 0, 14'h000, 1, 0, 0, 0, 0, 0, 8'h0A, 1, 0, 1);
        add(C_MRS, 0, 14'h055, 1, 0, 0, 0, 0, 0, 8'h0A, 1, 0, 1);
        add(C_PRE, 0, 14'h400, 1, 1, E_PRE, 0, 14'h400, 1, 8'h00, 0, 0, 1);
        add(C_REF, 0, 14'h000, 1, 1, E_REF, 0, 14'h000, 0, 8'h00, 0, 0, 1);
        add(C_MRS, 0, 14'h523, 1, 1, E_MRS, 0, 14'h523, 0, 8'h00, 0, 0, 1);
        add(C_ZQ,  0, 14'h000, 1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1);
        add(C_DES, 0, 14'h000, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1);
        add(C_PRE, 6, 14'h000, 1, 1, E_PRE, 6, 14'h000, 0, 8'h00, 0, 0, 1);
        // PRE coinciding with tRCD expiry on bank 4 wins
        add(C_ACT, 4, 14'h001, 1, 1, E_ACT, 4, 14'h001, 0, 8'h10, 0, 0, 1);
        add(C_NOP, 0, 14'h000, 1, 0, 0, 0, 0, 0, 8'h10, 0, 0, 1);
        add(C_NOP, 0, 14'h000, 1, 0, 0, 0, 0, 0, 8'h10, 0, 0, 1);
        add(C_PRE, 4, 14'h000, 1, 1, E_PRE, 4, 14'h000, 0, 8'h00, 0, 0, 1);
        add(C_RD,  4, 14'h000, 1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1);
        // ACT to an open bank is illegal; other banks unaffected
        add(C_ACT, 7, 14'h002, 1, 1, E_ACT, 7, 14'h002, 0, 8'h80, 0, 0, 1);
        add(C_ACT, 7, 14'h003, 1, 0, 0, 0, 0, 0, 8'h80, 1, 0, 1);
        add(C_ACT, 6, 14'h004, 1, 1, E_ACT, 6, 14'h004, 0, 8'hC0, 0, 0, 1);
        add(C_PRE, 0, 14'h400, 1, 1, E_PRE, 0, 14'h400, 1, 8'h00, 0, 0, 1);
        add(C_NOP, 0, 14'h000, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1);
        // Fill with out_ready=0, overflow, illegal-beats-overflow, push+pop while full, drain
        add(C_ACT, 0, 14'h00A, 0, 1, E_ACT, 0, 14'h00A, 0, 8'h01, 0, 0, 1);
        add(C_PRE, 0, 14'h000, 0, 1, E_ACT, 0, 14'h00A, 0, 8'h00, 0, 0, 1);
        add(C_ACT, 0, 14'h00B, 0, 1, E_ACT, 0, 14'h00A, 0, 8'h01, 0, 0, 1);
        add(C_PRE, 0, 14'h000, 0, 1, E_ACT, 0, 14'h00A, 0, 8'h00, 0, 0, 0);
        add(C_ACT, 1, 14'h00C, 0, 1, E_ACT, 0, 14'h00A, 0, 8'h02, 0, 1, 0);
        add(C_RD,  3, 14'h000, 0, 1, E_ACT, 0, 14'h00A, 0, 8'h02, 1, 0, 0);
        add(C_PRE, 1, 14'h000, 1, 1, E_PRE, 0, 14'h000, 0, 8'h00, 0, 0, 0);
        add(C_NOP, 0, 14'h000, 1, 1, E_ACT, 0, 14'h00B, 0, 8'h00, 0, 0, 1);
        add(C_NOP, 0, 14'h000, 1, 1, E_PRE, 0, 14'h000, 0, 8'h00, 0, 0, 1);
        add(C_NOP, 0, 14'h000, 1, 1, E_PRE, 1, 14'h000, 0, 8'h00, 0, 0, 1);
        add(C_NOP, 0, 14'h000, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1);

        // Reset state: everything zero, in_ready held low
        reset = 1'b1;
        drive(C_NOP, 0, 14'h000, 0);
        repeat (2) step();
        check("reset_state",
              {out_valid, out_op, out_bank, out_addr, out_ap, bank_open, err_illegal, err_overflow, in_ready},
              33'h0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].cmd, vecs[k].ba, vecs[k].addr, vecs[k].ordy);
            step();
            check($sformatf("vec%0d", k), observe(),
                  pack(vecs[k].ev, vecs[k].eop, vecs[k].eb, vecs[k].ea, vecs[k].eap,
                       vecs[k].eopen, vecs[k].eill, vecs[k].eovf, vecs[k].eirdy));
        end

        // Reset with three queued entries and bank 5 mid-ACTIVATING
        drive(C_ACT, 5, 14'h001, 0); step();
        drive(C_PRE, 0, 14'h000, 0); step();
        drive(C_PRE, 1, 14'h000, 0); step();
        check("pre_reset", observe(), pack(1, E_ACT, 5, 14'h001, 0, 8'h20, 0, 0, 1));
        reset = 1'b1;
        drive(C_ACT, 2, 14'h007, 0);
        step();
        check("in_reset",
              {out_valid, out_op, out_bank, out_addr, out_ap, bank_open, err_illegal, err_overflow, in_ready},
              33'h0);
        reset = 1'b0;
        drive(C_NOP, 0, 14'h000, 1); step();
        check("post_reset", observe(), pack(0, 0, 0, 0, 0, 8'h00, 0, 0, 1));
        drive(C_RD, 5, 14'h000, 1); step();
        check("rd_after_reset", observe(), pack(0, 0, 0, 0, 0, 8'h00, 1, 0, 1));
        drive(C_ACT, 5, 14'h009, 1); step();
        check("act_after_reset", observe(), pack(1, E_ACT, 5, 14'h009, 0, 8'h20, 0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
